// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and address-field helpers for the
// direct-mapped write-through byte cache.
package cache_pkg;

  localparam int ADDR_W   = 8;
  localparam int BYTE_W   = 8;
  localparam int BLOCK_W  = 32;
  localparam int LINES    = 8;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RD_DONE,
    S_WRITE,
    S_WR_DONE
  } state_e;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  // Byte k of a block sits in bits [8k+7:8k].
  function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/cache_store.sv
// Tag, valid and data arrays of the cache. Combinational lookup by index;
// writes are either a full block fill (with tag) or a single byte update.
module cache_store
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [TAG_W-1:0]    rd_tag_i,
  output logic                hit_o,
  output logic [BLOCK_W-1:0]  rd_block_o,
  input  logic                fill_en_i,
  input  logic [INDEX_W-1:0]  fill_index_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [BLOCK_W-1:0]  fill_block_i,
  input  logic                byte_en_i,
  input  logic [INDEX_W-1:0]  byte_index_i,
  input  logic [OFFSET_W-1:0] byte_offset_i,
  input  logic [BYTE_W-1:0]   byte_data_i
);

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_index_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately left out of reset; clearing valid_q
  // is enough to make every line miss, and it keeps these as plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_index_i]  <= fill_tag_i;
      data_q[fill_index_i] <= fill_block_i;
    end else if (byte_en_i) begin
      data_q[byte_index_i][{byte_offset_i, 3'b000} +: BYTE_W] <= byte_data_i;
    end
  end

  assign hit_o      = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_block_o = data_q[rd_index_i];

endmodule

// File: rtl/cache.sv
// Direct-mapped, write-through, no-write-allocate byte cache (8 lines x 4 B)
// between a byte-wide processor port and a word-wide memory port.
module cache
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               PRead_request,
  input  logic               PWrite_request,
  input  logic [ADDR_W-1:0]  PAddress,
  input  logic [BYTE_W-1:0]  PWrite_data,
  output logic [BYTE_W-1:0]  PRead_data,
  output logic               PRead_ready,
  output logic               PWrite_done,
  output logic               MRead_request,
  output logic               MWrite_request,
  output logic [ADDR_W-1:0]  MAddress,
  output logic [BYTE_W-1:0]  MWrite_data,
  input  logic [BLOCK_W-1:0] MRead_data,
  input  logic               MRead_ready,
  input  logic               MWrite_done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   prdata_q, prdata_d;
  logic                prready_q, prready_d;
  logic                pwdone_q, pwdone_d;
  logic                mrreq_q, mrreq_d;
  logic                mwreq_q, mwreq_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [BYTE_W-1:0]   mwdata_q, mwdata_d;

  logic [ADDR_W-1:0]   look_addr;
  logic                hit;
  logic [BLOCK_W-1:0]  rd_block;
  logic                fill_en;
  logic                byte_en;

  // In IDLE the request is decided on the live address; afterwards every
  // lookup (notably the write-hit check) uses the latched one.
  assign look_addr = (state_q == S_IDLE) ? PAddress : addr_q;

  cache_store u_store (
    .clk           (clk),
    .rst           (rst),
    .rd_index_i    (addr_index(look_addr)),
    .rd_tag_i      (addr_tag(look_addr)),
    .hit_o         (hit),
    .rd_block_o    (rd_block),
    .fill_en_i     (fill_en),
    .fill_index_i  (addr_index(addr_q)),
    .fill_tag_i    (addr_tag(addr_q)),
    .fill_block_i  (MRead_data),
    .byte_en_i     (byte_en),
    .byte_index_i  (addr_index(addr_q)),
    .byte_offset_i (addr_offset(addr_q)),
    .byte_data_i   (mwdata_q)
  );

  // NOTE: every signal is given a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  // NOTE: combinational logic uses blocking '='; only the clocked block below
  // uses non-blocking '<=' so all registers update together at the edge.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prdata_d  = prdata_q;
    prready_d = prready_q;
    pwdone_d  = pwdone_q;
    mrreq_d   = mrreq_q;
    mwreq_d   = mwreq_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    fill_en   = 1'b0;
    byte_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (PRead_request) begin
          addr_d = PAddress;
          if (hit) begin
            prdata_d  = block_byte(rd_block, addr_offset(PAddress));
            prready_d = 1'b1;
            state_d   = S_RD_DONE;
          end else begin
            mrreq_d = 1'b1;
            maddr_d = {PAddress[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            state_d = S_FETCH;
          end
        end else if (PWrite_request) begin
          addr_d   = PAddress;
          mwreq_d  = 1'b1;
          maddr_d  = PAddress;
          mwdata_d = PWrite_data;
          state_d  = S_WRITE;
        end
      end

      S_FETCH: begin
        if (MRead_ready) begin
          fill_en   = 1'b1;
          prdata_d  = block_byte(MRead_data, addr_offset(addr_q));
          mrreq_d   = 1'b0;
          prready_d = 1'b1;
          state_d   = S_RD_DONE;
        end
      end

      S_RD_DONE: begin
        if (!PRead_request) begin
          prready_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      // Completion does not depend on PWrite_request: the memory write always
      // finishes, and WR_DONE then shows a one-cycle done if it already dropped.
      S_WRITE: begin
        if (MWrite_done) begin
          mwreq_d  = 1'b0;
          byte_en  = hit;
          pwdone_d = 1'b1;
          state_d  = S_WR_DONE;
        end
      end

      S_WR_DONE: begin
        if (!PWrite_request) begin
          pwdone_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      prdata_q  <= '0;
      prready_q <= 1'b0;
      pwdone_q  <= 1'b0;
      mrreq_q   <= 1'b0;
      mwreq_q   <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prdata_q  <= prdata_d;
      prready_q <= prready_d;
      pwdone_q  <= pwdone_d;
      mrreq_q   <= mrreq_d;
      mwreq_q   <= mwreq_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
    end
  end

  assign PRead_data     = prdata_q;
  assign PRead_ready    = prready_q;
  assign PWrite_done    = pwdone_q;
  assign MRead_request  = mrreq_q;
  assign MWrite_request = mwreq_q;
  assign MAddress       = maddr_q;
  assign MWrite_data    = mwdata_q;

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: table of processor operations against a
// byte memory model (mem[i]=i), with queues of expected fetches, writes and reads.
module tb_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PRead_request, PWrite_request;
  logic [7:0]  PAddress, PWrite_data;
  logic [7:0]  PRead_data;
  logic        PRead_ready, PWrite_done;
  logic        MRead_request, MWrite_request;
  logic [7:0]  MAddress, MWrite_data;
  logic [31:0] MRead_data;
  logic        MRead_ready, MWrite_done;

  cache dut (
    .clk            (clk),
    .rst            (rst),
    .PRead_request  (PRead_request),
    .PWrite_request (PWrite_request),
    .PAddress       (PAddress),
    .PWrite_data    (PWrite_data),
    .PRead_data     (PRead_data),
    .PRead_ready    (PRead_ready),
    .PWrite_done    (PWrite_done),
    .MRead_request  (MRead_request),
    .MWrite_request (MWrite_request),
    .MAddress       (MAddress),
    .MWrite_data    (MWrite_data),
    .MRead_data     (MRead_data),
    .MRead_ready    (MRead_ready),
    .MWrite_done    (MWrite_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [256];
  logic [7:0]  exp_fetch_q [$];
  logic [15:0] exp_mw_q    [$];
  logic [7:0]  exp_rd_q    [$];
  int          mem_lat = 2;
  int          linger  = 0;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
    bit         miss;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: serves fetches/writes after mem_lat cycles and may hold
  // its ready/done high for 'linger' extra cycles after the request drops.
  initial begin
    bit rd_active, wr_active;
    int rd_cnt, wr_cnt, rd_hold, wr_hold, a;
    rd_active = 0; wr_active = 0; rd_cnt = 0; wr_cnt = 0; rd_hold = 0; wr_hold = 0;
    MRead_ready = 1'b0; MWrite_done = 1'b0; MRead_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        rd_active = 0; wr_active = 0; rd_hold = 0; wr_hold = 0;
        MRead_ready = 1'b0; MWrite_done = 1'b0;
      end else begin
        if (MRead_request && !rd_active) begin
          rd_active = 1; rd_cnt = 0;
          if (exp_fetch_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_fetch: MAddress=%0h, no fetch expected", MAddress);
          end else check("fetch_addr", MAddress, exp_fetch_q.pop_front());
        end
        if (rd_active) begin
          if (!MRead_request) begin
            rd_active = 0; rd_hold = linger;
          end else if (!MRead_ready) begin
            rd_cnt++;
            if (rd_cnt >= mem_lat) begin
              a = MAddress;
              MRead_data  = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
              MRead_ready = 1'b1;
            end
          end
        end
        if (!rd_active && MRead_ready) begin
          if (rd_hold > 0) rd_hold--; else MRead_ready = 1'b0;
        end

        if (MWrite_request && !wr_active) begin
          wr_active = 1; wr_cnt = 0;
          if (exp_mw_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: MAddress=%0h data=%0h, no write expected",
                     MAddress, MWrite_data);
          end else check("mem_write_addr_data", {MAddress, MWrite_data}, exp_mw_q.pop_front());
        end
        if (wr_active) begin
          if (!MWrite_request) begin
            wr_active = 0; wr_hold = linger;
          end else if (!MWrite_done) begin
            wr_cnt++;
            if (wr_cnt >= mem_lat) begin
              mem[MAddress] = MWrite_data;
              MWrite_done   = 1'b1;
            end
          end
        end
        if (!wr_active && MWrite_done) begin
          if (wr_hold > 0) wr_hold--; else MWrite_done = 1'b0;
        end
      end
    end
  end

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input bit miss);
    int lat;
    bit got;
    logic [7:0] e;
    if (miss) exp_fetch_q.push_back({a[7:2], 2'b00});
    exp_rd_q.push_back(exp);
    PAddress = a;
    PRead_request = 1'b1;
    got = 0; lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (PRead_ready) begin lat = i; got = 1; break; end
    end
    e = exp_rd_q.pop_front();
    if (!got) begin
      total++; bad++;
      $display("FAIL rd_timeout: addr=%0h no PRead_ready, expected data %0h", a, e);
    end else begin
      check($sformatf("rd_data@%0h", a), PRead_data, e);
      if (!miss) check($sformatf("hit_latency@%0h", a), lat, 1);
    end
    PRead_request = 1'b0;
    @(negedge clk);
    check("rd_ready_drop", PRead_ready, 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    bit got;
    exp_mw_q.push_back({a, d});
    PAddress = a;
    PWrite_data = d;
    PWrite_request = 1'b1;
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (PWrite_done) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL wr_timeout: addr=%0h no PWrite_done seen, required 1", a);
    end
    PWrite_request = 1'b0;
    @(negedge clk);
    check("wr_done_drop", PWrite_done, 0);
    check($sformatf("mem@%0h", a), mem[a], d);
  endtask

  function automatic vec_t mk(input bit w, input logic [7:0] a, input logic [7:0] d, input bit m);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.miss = m;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    bit got;
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    PRead_request = 1'b0; PWrite_request = 1'b0; PAddress = '0; PWrite_data = '0;

    vecs[0]  = mk(0, 8'h05, 8'h05, 1);
    vecs[1]  = mk(0, 8'h03, 8'h03, 1);
    vecs[2]  = mk(0, 8'h07, 8'h07, 0);
    vecs[3]  = mk(0, 8'h01, 8'h01, 0);
    vecs[4]  = mk(0, 8'h26, 8'h26, 1);
    vecs[5]  = mk(0, 8'h05, 8'h05, 1);
    vecs[6]  = mk(1, 8'h02, 8'hFB, 0);
    vecs[7]  = mk(0, 8'h02, 8'hFB, 0);
    vecs[8]  = mk(1, 8'h22, 8'hAB, 0);
    vecs[9]  = mk(0, 8'h02, 8'hFB, 0);
    vecs[10] = mk(0, 8'h22, 8'hAB, 1);
    vecs[11] = mk(0, 8'h03, 8'h03, 1);
    vecs[12] = mk(0, 8'h02, 8'hFB, 0);

    repeat (3) @(negedge clk);
    check("reset_outputs", {PRead_data, PRead_ready, PWrite_done, MRead_request,
                            MWrite_request, MAddress, MWrite_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].data, vecs[i].miss);
    end

    // Reset while a fetch is outstanding.
    mem_lat = 10;
    exp_fetch_q.push_back(8'h10);
    PAddress = 8'h10;
    PRead_request = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MRead_request) begin got = 1; break; end
    end
    check("fetch_started_before_reset", got, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", {PRead_data, PRead_ready, PWrite_done, MRead_request,
                                  MWrite_request, MAddress, MWrite_data}, 0);
    PRead_request = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_lat = 2;
    @(negedge clk);
    do_read(8'h07, 8'h07, 1);

    // Read and write together: the read goes first, the write follows.
    PAddress = 8'h05; PWrite_data = 8'h55;
    PRead_request = 1'b1; PWrite_request = 1'b1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (PRead_ready) begin got = 1; break; end
    end
    check("dual_read_ready", got, 1);
    check("dual_read_data", PRead_data, 8'h05);
    check("dual_no_mem_write", MWrite_request, 0);
    exp_mw_q.push_back({8'h05, 8'h55});
    PRead_request = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (PWrite_done) begin got = 1; break; end
    end
    check("dual_write_done", got, 1);
    PWrite_request = 1'b0;
    @(negedge clk);
    do_read(8'h05, 8'h55, 0);

    // Write request dropped mid-operation: memory write completes, done pulses once.
    exp_mw_q.push_back({8'h40, 8'h66});
    PAddress = 8'h40; PWrite_data = 8'h66; PWrite_request = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MWrite_request) begin got = 1; break; end
    end
    check("drop_mwrite_started", got, 1);
    PWrite_request = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (PWrite_done) cnt++;
    end
    check("drop_done_pulse_cycles", cnt, 1);
    check("drop_mem@40", mem[8'h40], 8'h66);

    // Stale-high MWrite_done / MRead_ready must not disturb later operations.
    linger = 3;
    do_write(8'h06, 8'h77);
    do_read(8'h06, 8'h77, 0);
    do_read(8'h0A, 8'h0A, 1);
    do_read(8'h09, 8'h09, 0);
    linger = 0;
    repeat (6) @(negedge clk);

    check("fetch_queue_empty", exp_fetch_q.size(), 0);
    check("write_queue_empty", exp_mw_q.size(), 0);
    check("read_queue_empty", exp_rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
